charram_dram_ctrl: RTL and testbench

CHARRAM_DRAM_CTRL -- requirements
Module: charram_dram_ctrl

---
 rtl/charram_dram_ctrl_if.sv | 39 +++
 rtl/charram_dram_ctrl.sv | 172 +++++++++++++++++
 tb/tb_charram_dram_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/charram_dram_ctrl_if.sv
// Requester and DRAM-side bus of the character-RAM DRAM controller.
// Signal names are seen from the controller: i_* enter it, o_* leave it.
`timescale 1ns/1ps
interface charram_dram_ctrl_if;
    // Video fetch port
    logic        i_VID_REQ;
    logic [13:0] i_VID_ADDR;
    logic [3:0]  o_VID_DATA;
    logic        o_VID_VALID;
    // CPU port
    logic        i_CPU_REQ;
    logic        i_CPU_WR;
    logic [13:0] i_CPU_ADDR;
    logic [3:0]  i_CPU_DIN;
    logic [3:0]  o_CPU_DOUT;
    logic        o_CPU_ACK;
    // DRAM pins
    logic [7:0]  o_DRAM_ADDR;
    logic [3:0]  o_DRAM_DIN;
    logic [3:0]  i_DRAM_DOUT;
    logic        o_RAS_n;
    logic        o_CAS_n;
    logic        o_WR_n;
    logic        o_RD_n;

    // Controller side
    modport slave (
        input  i_VID_REQ, i_VID_ADDR, i_CPU_REQ, i_CPU_WR, i_CPU_ADDR, i_CPU_DIN, i_DRAM_DOUT,
        output o_VID_DATA, o_VID_VALID, o_CPU_DOUT, o_CPU_ACK,
               o_DRAM_ADDR, o_DRAM_DIN, o_RAS_n, o_CAS_n, o_WR_n, o_RD_n
    );

    // Requester / DRAM-model side
    modport master (
        output i_VID_REQ, i_VID_ADDR, i_CPU_REQ, i_CPU_WR, i_CPU_ADDR, i_CPU_DIN, i_DRAM_DOUT,
        input  o_VID_DATA, o_VID_VALID, o_CPU_DOUT, o_CPU_ACK,
               o_DRAM_ADDR, o_DRAM_DIN, o_RAS_n, o_CAS_n, o_WR_n, o_RD_n
    );
endinterface

// File: rtl/charram_dram_ctrl.sv
// Character-RAM DRAM controller: arbitrates video fetches, RAS-only refresh
// and CPU accesses onto a multiplexed-address nibble-wide DRAM. All DRAM
// strobes and requester outputs are registered; the FSM advances on i_CEN ticks.
`timescale 1ns/1ps
module charram_dram_ctrl #(
    parameter int unsigned REFRESH_INTERVAL = 64
) (
    input  logic                 i_MCLK,
    input  logic                 i_RST_n,
    input  logic                 i_CEN,
    charram_dram_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW,
        S_COL,
        S_XFER,
        S_LATCH,
        S_PRE,
        S_RFSH
    } state_t;

    localparam logic [7:0] RFSH_LAST = 8'(REFRESH_INTERVAL - 1);

    state_t      state_q;
    logic [13:0] addr_q;       // address latched at grant
    logic        wr_q;         // direction latched at grant
    logic [3:0]  din_q;        // write nibble latched at grant
    logic        src_vid_q;    // access belongs to the video port
    logic        is_rfsh_q;    // current cycle is a refresh
    logic [7:0]  rfsh_cnt_q;
    logic [7:0]  rfsh_row_q;
    logic        rfsh_pend_q;

    logic        ras_n_q, cas_n_q, wr_n_q, rd_n_q;
    logic [7:0]  dram_addr_q;
    logic [3:0]  dram_din_q;
    logic [3:0]  vid_data_q, cpu_dout_q;
    logic        vid_valid_q, cpu_ack_q;

    // Arbitration, DRAM sequencing, refresh timing and registered outputs
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            din_q       <= '0;
            src_vid_q   <= 1'b0;
            is_rfsh_q   <= 1'b0;
            rfsh_cnt_q  <= '0;
            rfsh_row_q  <= '0;
            rfsh_pend_q <= 1'b0;
            ras_n_q     <= 1'b1;
            cas_n_q     <= 1'b1;
            wr_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            dram_addr_q <= '0;
            dram_din_q  <= '0;
            vid_data_q  <= '0;
            cpu_dout_q  <= '0;
            vid_valid_q <= 1'b0;
            cpu_ack_q   <= 1'b0;
        end else begin
            // Completion pulses last a single MCLK, tick or not.
            vid_valid_q <= 1'b0;
            cpu_ack_q   <= 1'b0;
            if (i_CEN) begin
                case (state_q)
                    S_IDLE: begin
                        rfsh_cnt_q <= (rfsh_cnt_q == RFSH_LAST) ? 8'd0 : rfsh_cnt_q + 8'd1;
                        if (bus.i_VID_REQ) begin
                            state_q     <= S_ROW;
                            addr_q      <= bus.i_VID_ADDR;
                            wr_q        <= 1'b0;
                            src_vid_q   <= 1'b1;
                            is_rfsh_q   <= 1'b0;
                            ras_n_q     <= 1'b0;
                            dram_addr_q <= bus.i_VID_ADDR[7:0];
                        end else if (rfsh_pend_q) begin
                            state_q     <= S_ROW;
                            is_rfsh_q   <= 1'b1;
                            src_vid_q   <= 1'b0;
                            rfsh_pend_q <= 1'b0;
                            ras_n_q     <= 1'b0;
                            dram_addr_q <= rfsh_row_q;
                        end else if (bus.i_CPU_REQ) begin
                            state_q     <= S_ROW;
                            addr_q      <= bus.i_CPU_ADDR;
                            wr_q        <= bus.i_CPU_WR;
                            din_q       <= bus.i_CPU_DIN;
                            src_vid_q   <= 1'b0;
                            is_rfsh_q   <= 1'b0;
                            ras_n_q     <= 1'b0;
                            dram_addr_q <= bus.i_CPU_ADDR[7:0];
                        end
                        // NOTE: the last non-blocking assignment wins, so a counter
                        // wrap on a refresh-grant tick re-arms the request instead
                        // of losing it.
                        if (rfsh_cnt_q == RFSH_LAST) begin
                            rfsh_pend_q <= 1'b1;
                        end
                    end
                    S_ROW: begin
                        if (is_rfsh_q) begin
                            state_q <= S_RFSH;
                        end else begin
                            state_q     <= S_COL;
                            cas_n_q     <= 1'b0;
                            dram_addr_q <= {1'b0, addr_q[13:8], 1'b0};
                        end
                    end
                    S_COL: begin
                        state_q <= S_XFER;
                        if (wr_q) begin
                            wr_n_q     <= 1'b0;
                            dram_din_q <= din_q;
                        end else begin
                            rd_n_q <= 1'b0;
                        end
                    end
                    S_XFER: begin
                        state_q <= S_LATCH;
                    end
                    S_LATCH: begin
                        state_q <= S_PRE;
                        ras_n_q <= 1'b1;
                        cas_n_q <= 1'b1;
                        wr_n_q  <= 1'b1;
                        rd_n_q  <= 1'b1;
                        if (src_vid_q) begin
                            vid_data_q  <= bus.i_DRAM_DOUT;
                            vid_valid_q <= 1'b1;
                        end else begin
                            if (!wr_q) begin
                                cpu_dout_q <= bus.i_DRAM_DOUT;
                            end
                            cpu_ack_q <= 1'b1;
                        end
                    end
                    S_RFSH: begin
                        state_q    <= S_PRE;
                        ras_n_q    <= 1'b1;
                        rfsh_row_q <= rfsh_row_q + 8'd1;
                    end
                    S_PRE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        ras_n_q <= 1'b1;
                        cas_n_q <= 1'b1;
                        wr_n_q  <= 1'b1;
                        rd_n_q  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.o_RAS_n     = ras_n_q;
    assign bus.o_CAS_n     = cas_n_q;
    assign bus.o_WR_n      = wr_n_q;
    assign bus.o_RD_n      = rd_n_q;
    assign bus.o_DRAM_ADDR = dram_addr_q;
    assign bus.o_DRAM_DIN  = dram_din_q;
    assign bus.o_VID_DATA  = vid_data_q;
    assign bus.o_VID_VALID = vid_valid_q;
    assign bus.o_CPU_DOUT  = cpu_dout_q;
    assign bus.o_CPU_ACK   = cpu_ack_q;

endmodule

// File: tb/tb_charram_dram_ctrl.sv
// Directed bench for charram_dram_ctrl: a nibble DRAM model behind the main
// instance, plus a second instance with a short refresh interval on an idle bus.
`timescale 1ns/1ps
module tb_charram_dram_ctrl;

    logic clk;
    logic rst_n;
    logic rrst_n;
    logic cen;

    int n_checks;
    int n_errors;

    charram_dram_ctrl_if vif ();
    charram_dram_ctrl_if rif ();

    charram_dram_ctrl #(.REFRESH_INTERVAL(64)) dut (
        .i_MCLK  (clk),
        .i_RST_n (rst_n),
        .i_CEN   (cen),
        .bus     (vif)
    );

    charram_dram_ctrl #(.REFRESH_INTERVAL(4)) dut_r (
        .i_MCLK  (clk),
        .i_RST_n (rrst_n),
        .i_CEN   (1'b1),
        .bus     (rif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DRAM model: row on RAS-only phase, column on CAS fall, write while WR_n low.
    logic [3:0] mem [0:65535];
    logic [7:0] m_row;
    logic [7:0] m_col;
    logic       m_cas_prev;

    initial begin
        m_row      = 8'h00;
        m_col      = 8'h00;
        m_cas_prev = 1'b1;
    end

    always @(negedge clk) begin
        if (!vif.o_RAS_n && vif.o_CAS_n) m_row <= vif.o_DRAM_ADDR;
        if (!vif.o_CAS_n && m_cas_prev)  m_col <= vif.o_DRAM_ADDR;
        m_cas_prev <= vif.o_CAS_n;
        if (!vif.o_WR_n && !vif.o_CAS_n) mem[{m_row, m_col}] <= vif.o_DRAM_DIN;
    end

    assign vif.i_DRAM_DOUT = !vif.o_RD_n ? mem[{m_row, m_col}] : 4'h0;
    assign rif.i_DRAM_DOUT = 4'h0;

    logic [3:0] strb;
    assign strb = {vif.o_RAS_n, vif.o_CAS_n, vif.o_WR_n, vif.o_RD_n};

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        vif.i_VID_REQ  = 1'b0;
        vif.i_CPU_REQ  = 1'b0;
        vif.i_CPU_WR   = 1'b0;
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cen      = 1'b1;
        rrst_n   = 1'b0;
        vif.i_VID_REQ  = 1'b0;
        vif.i_VID_ADDR = 14'h0;
        vif.i_CPU_REQ  = 1'b0;
        vif.i_CPU_WR   = 1'b0;
        vif.i_CPU_ADDR = 14'h0;
        vif.i_CPU_DIN  = 4'h0;
        rif.i_VID_REQ  = 1'b0;
        rif.i_VID_ADDR = 14'h0;
        rif.i_CPU_REQ  = 1'b0;
        rif.i_CPU_WR   = 1'b0;
        rif.i_CPU_ADDR = 14'h0;
        rif.i_CPU_DIN  = 4'h0;

        // ---- Reset values
        rst_n = 1'b0;
        #12;
        check("rst_strobes", 16'(strb), 16'hF);
        check("rst_addr",    16'(vif.o_DRAM_ADDR), 16'h0);
        check("rst_din",     16'(vif.o_DRAM_DIN), 16'h0);
        check("rst_vdata",   16'(vif.o_VID_DATA), 16'h0);
        check("rst_cdout",   16'(vif.o_CPU_DOUT), 16'h0);
        check("rst_pulses",  16'({vif.o_VID_VALID, vif.o_CPU_ACK}), 16'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ---- CPU write 0x2A5C <- 9, then read it back
        vif.i_CPU_REQ = 1'b1; vif.i_CPU_WR = 1'b1; vif.i_CPU_ADDR = 14'h2A5C; vif.i_CPU_DIN = 4'h9;
        tick();
        check("wr_row_strb", 16'(strb), 16'h7);
        check("wr_row_addr", 16'(vif.o_DRAM_ADDR), 16'h5C);
        tick();
        check("wr_col_strb", 16'(strb), 16'h3);
        check("wr_col_addr", 16'(vif.o_DRAM_ADDR), 16'h54);
        tick();
        check("wr_xfer_strb", 16'(strb), 16'h1);
        check("wr_xfer_din",  16'(vif.o_DRAM_DIN), 16'h9);
        tick();
        check("wr_latch_strb", 16'(strb), 16'h1);
        check("wr_latch_ack",  16'(vif.o_CPU_ACK), 16'h0);
        tick();
        check("wr_pre_strb", 16'(strb), 16'hF);
        check("wr_ack",      16'(vif.o_CPU_ACK), 16'h1);
        vif.i_CPU_REQ = 1'b0;
        tick();
        check("wr_ack_once", 16'(vif.o_CPU_ACK), 16'h0);

        vif.i_CPU_REQ = 1'b1; vif.i_CPU_WR = 1'b0; vif.i_CPU_ADDR = 14'h2A5C;
        tick();
        check("rd_row_addr", 16'(vif.o_DRAM_ADDR), 16'h5C);
        tick();
        check("rd_col_addr", 16'(vif.o_DRAM_ADDR), 16'h54);
        tick();
        check("rd_xfer_strb", 16'(strb), 16'h2);
        tick();
        check("rd_latch_ack", 16'(vif.o_CPU_ACK), 16'h0);
        tick();
        check("rd_ack",  16'(vif.o_CPU_ACK), 16'h1);
        check("rd_data", 16'(vif.o_CPU_DOUT), 16'h9);
        vif.i_CPU_REQ = 1'b0;
        tick();
        check("rd_ack_once", 16'(vif.o_CPU_ACK), 16'h0);
        check("rd_data_hold", 16'(vif.o_CPU_DOUT), 16'h9);

        // ---- Video and CPU together: video first, CPU (write 0x0100 <- A) next
        do_reset();
        vif.i_VID_REQ = 1'b1; vif.i_VID_ADDR = 14'h2A5C;
        vif.i_CPU_REQ = 1'b1; vif.i_CPU_WR = 1'b1; vif.i_CPU_ADDR = 14'h0100; vif.i_CPU_DIN = 4'hA;
        tick();
        vif.i_VID_REQ = 1'b0;
        check("arb_vid_row", 16'(vif.o_DRAM_ADDR), 16'h5C);
        tick();
        tick();
        check("arb_vid_rd", 16'(strb), 16'h2);
        tick();
        tick();
        check("arb_valid", 16'(vif.o_VID_VALID), 16'h1);
        check("arb_vdata", 16'(vif.o_VID_DATA), 16'h9);
        check("arb_no_ack", 16'(vif.o_CPU_ACK), 16'h0);
        tick();
        check("arb_valid_once", 16'(vif.o_VID_VALID), 16'h0);
        check("arb_idle_strb", 16'(strb), 16'hF);
        tick();
        check("arb_cpu_row", 16'({strb, vif.o_DRAM_ADDR}), 16'h700);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("arb_cpu_wait", 16'(vif.o_CPU_ACK), 16'h0);
        end
        tick();
        check("arb_cpu_ack", 16'(vif.o_CPU_ACK), 16'h1);
        vif.i_CPU_REQ = 1'b0;

        // ---- Pending refresh and CPU together; CPU address changed after grant
        do_reset();
        repeat (64) tick();
        vif.i_CPU_REQ = 1'b1; vif.i_CPU_WR = 1'b0; vif.i_CPU_ADDR = 14'h2A5C;
        tick();
        check("rf_row", 16'({strb, vif.o_DRAM_ADDR}), 16'h700);
        tick();
        check("rf_rfsh_strb", 16'(strb), 16'h7);
        check("rf_rfsh_ack", 16'(vif.o_CPU_ACK), 16'h0);
        tick();
        check("rf_pre_strb", 16'(strb), 16'hF);
        tick();
        check("rf_idle_strb", 16'(strb), 16'hF);
        tick();
        check("rf_cpu_row", 16'({strb, vif.o_DRAM_ADDR}), 16'h75C);
        vif.i_CPU_ADDR = 14'h0100; vif.i_CPU_WR = 1'b1; vif.i_CPU_DIN = 4'h3;
        tick();
        check("rf_cpu_col", 16'(vif.o_DRAM_ADDR), 16'h54);
        tick();
        check("rf_cpu_dir", 16'(strb), 16'h2);
        tick();
        tick();
        check("rf_cpu_ack",  16'(vif.o_CPU_ACK), 16'h1);
        check("rf_cpu_data", 16'(vif.o_CPU_DOUT), 16'h9);
        vif.i_CPU_REQ = 1'b0;

        // ---- Reset during XFER of a read, then the read again
        do_reset();
        vif.i_CPU_REQ = 1'b1; vif.i_CPU_WR = 1'b0; vif.i_CPU_ADDR = 14'h2A5C;
        tick();
        tick();
        tick();
        check("ab_xfer_strb", 16'(strb), 16'h2);
        rst_n = 1'b0;
        #1;
        check("ab_strobes", 16'(strb), 16'hF);
        check("ab_addr",    16'(vif.o_DRAM_ADDR), 16'h0);
        @(posedge clk);
        #1;
        check("ab_no_ack", 16'(vif.o_CPU_ACK), 16'h0);
        rst_n = 1'b1;
        tick();
        check("ab_row", 16'({strb, vif.o_DRAM_ADDR}), 16'h75C);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ab_wait", 16'(vif.o_CPU_ACK), 16'h0);
        end
        tick();
        check("ab_ack",  16'(vif.o_CPU_ACK), 16'h1);
        check("ab_data", 16'(vif.o_CPU_DOUT), 16'h9);
        vif.i_CPU_REQ = 1'b0;

        // ---- CPU request dropped before any tick: no access, no ack
        do_reset();
        cen = 1'b0;
        vif.i_CPU_REQ = 1'b1; vif.i_CPU_WR = 1'b0; vif.i_CPU_ADDR = 14'h0100;
        repeat (3) tick();
        vif.i_CPU_REQ = 1'b0;
        cen = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("drop_idle", 16'({strb, vif.o_CPU_ACK}), 16'h1E);
        end

        // ---- CEN low for 10 MCLK mid-access (read 0x0100 = A)
        vif.i_CPU_REQ = 1'b1; vif.i_CPU_WR = 1'b0; vif.i_CPU_ADDR = 14'h0100;
        tick();
        tick();
        check("cen_col", 16'({strb, vif.o_DRAM_ADDR}), 16'h302);
        cen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("cen_frozen", 16'({strb, vif.o_DRAM_ADDR, 3'b000, vif.o_CPU_ACK}), 16'h3020);
        end
        cen = 1'b1;
        tick();
        check("cen_xfer", 16'(strb), 16'h2);
        tick();
        tick();
        check("cen_ack",  16'(vif.o_CPU_ACK), 16'h1);
        check("cen_data", 16'(vif.o_CPU_DOUT), 16'hA);
        vif.i_CPU_REQ = 1'b0;

        // ---- Idle bus, interval 4: RAS-only refresh rows 0,1,2,... with wrap
        begin
            logic cas_seen_low;
            cas_seen_low = 1'b0;
            rrst_n = 1'b1;
            for (int k = 0; k < 258; k++) begin
                for (int t = 0; t < ((k == 0) ? 5 : 7); t++) begin
                    tick();
                    if (!rif.o_CAS_n || !rif.o_RD_n || !rif.o_WR_n) cas_seen_low = 1'b1;
                end
                check("rfsh_row", 16'({rif.o_RAS_n, 7'd0, rif.o_DRAM_ADDR}), 16'(k % 256));
            end
            check("rfsh_cas_high", 16'(cas_seen_low), 16'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
